// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, opcode encodings and data-memory byte mask.
// Pure type/constant package, no logic and no latency.
// No flow control; the helper functions classify opcodes combinationally.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_add  = 4'b0001;
  localparam lc3b_opcode op_ldb  = 4'b0010;
  localparam lc3b_opcode op_stb  = 4'b0011;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_and  = 4'b0101;
  localparam lc3b_opcode op_ldr  = 4'b0110;
  localparam lc3b_opcode op_str  = 4'b0111;
  localparam lc3b_opcode op_rti  = 4'b1000;
  localparam lc3b_opcode op_not  = 4'b1001;
  localparam lc3b_opcode op_ldi  = 4'b1010;
  localparam lc3b_opcode op_sti  = 4'b1011;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_shf  = 4'b1101;
  localparam lc3b_opcode op_lea  = 4'b1110;
  localparam lc3b_opcode op_trap = 4'b1111;

  // LDI/STI fetch a pointer first, then access the pointed-to word.
  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  // LDB/STB touch a single byte lane selected by addr[0].
  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

  // Opcodes whose final access is a write.
  function automatic logic is_store_op(input lc3b_opcode op);
    return (op == op_str) || (op == op_stb) || (op == op_sti);
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data memory: write mask/data replication and load byte extract.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs in the same cycle.
module mem_byte_align
  import lc3b_types::*;
(
  input  logic          addr_lsb,
  input  logic          byte_op,
  input  logic          write_op,
  input  lc3b_word      wdata,
  input  lc3b_word      raw_rdata,
  output lc3b_mem_wmask wmask,
  output lc3b_word      store_data,
  output lc3b_word      load_data
);

  // Store side: masks and data are zero unless a write is actually being issued.
  always_comb begin
    wmask      = 2'b00;
    store_data = '0;
    if (write_op) begin
      if (byte_op) begin
        wmask      = addr_lsb ? 2'b10 : 2'b01;
        store_data = {wdata[7:0], wdata[7:0]};
      end else begin
        wmask      = 2'b11;
        store_data = wdata;
      end
    end
  end

  // Load side: byte ops pick the lane named by addr[0] and zero-extend it.
  always_comb begin
    load_data = raw_rdata;
    if (byte_op) begin
      load_data = {8'h00, addr_lsb ? raw_rdata[15:8] : raw_rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: single, byte-lane and two-access indirect accesses.
// Stalls for 1 + memory latency per access; result valid for one cycle in S_DONE.
// Requests held until dmem_resp; optional abort on timeout when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_opcode    opcode,
  input  logic          mem2_read,
  input  logic          mem2_write,
  input  lc3b_word      addr,
  input  lc3b_word      wdata,
  input  lc3b_word      dmem_rdata,
  input  logic          dmem_resp,
  output lc3b_word      dmem_address,
  output logic          dmem_read,
  output logic          dmem_write,
  output lc3b_mem_wmask dmem_wmask,
  output lc3b_word      dmem_wdata,
  output logic          mem_stall,
  output lc3b_word      rdata_out,
  output logic          rdata_valid,
  output logic          mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IND  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The wait counter is 8 bits wide, so the timeout must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in the range 1..256");
  end

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [14:0] ptr_reg;    // pointer word is always used word-aligned, bit 0 dropped
  lc3b_word    data_reg;
  logic        req;
  logic        ind;
  logic        byte_op;
  logic        store;
  logic        expired;

  assign req     = mem2_read | mem2_write;
  assign ind     = is_indirect(opcode);
  assign byte_op = is_byte_op(opcode);
  assign store   = is_store_op(opcode);

  // Next-state and request generation; requests exist only in S_IND/S_DATA.
  always_comb begin
    state_nxt    = state;
    dmem_address = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = ind ? S_IND : S_DATA;
      end
      S_IND: begin
        dmem_read    = 1'b1;
        dmem_address = {addr[15:1], 1'b0};
        if (dmem_resp)    state_nxt = S_DATA;
        else if (expired) state_nxt = S_DONE;
      end
      S_DATA: begin
        if (ind)          dmem_address = {ptr_reg, 1'b0};
        else if (byte_op) dmem_address = addr;
        else              dmem_address = {addr[15:1], 1'b0};
        dmem_read  = ~store;
        dmem_write = store;
        if (dmem_resp || expired) state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus capture of pointer and data words on each response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr_reg  <= '0;
      data_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IND && dmem_resp) ptr_reg <= dmem_rdata[15:1];
      if (state == S_DATA && dmem_resp) data_reg <= dmem_rdata;
      else if (expired) data_reg <= '0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       abort_flag;

  assign expired = ((state == S_IND) || (state == S_DATA)) && !dmem_resp &&
                   (wait_cnt == WAIT_LAST);

  // Per-access wait counter, cleared on every state change; abort flag marks the S_DONE it causes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      abort_flag <= 1'b0;
    end else begin
      abort_flag <= expired;
      if (state_nxt != state) wait_cnt <= '0;
      else if (((state == S_IND) || (state == S_DATA)) && !dmem_resp) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign mem_err = (state == S_DONE) && abort_flag;
`else
  assign expired = 1'b0;
  assign mem_err = 1'b0;
`endif

  mem_byte_align u_align (
    .addr_lsb   (addr[0]),
    .byte_op    (byte_op),
    .write_op   (dmem_write),
    .wdata      (wdata),
    .raw_rdata  (data_reg),
    .wmask      (dmem_wmask),
    .store_data (dmem_wdata),
    .load_data  (rdata_out)
  );

  assign mem_stall   = ((state == S_IDLE) && req) || (state == S_IND) || (state == S_DATA);
  assign rdata_valid = (state == S_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a sparse-memory reference model.
// Memory responder uses random 1..4 cycle latency; directed cases cover byte lanes, indirection, reset.
// Timeout abort is exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst;
  lc3b_opcode    opcode;
  logic          mem2_read;
  logic          mem2_write;
  lc3b_word      addr;
  lc3b_word      wdata;
  lc3b_word      dmem_rdata;
  logic          dmem_resp;
  lc3b_word      dmem_address;
  logic          dmem_read;
  logic          dmem_write;
  lc3b_mem_wmask dmem_wmask;
  lc3b_word      dmem_wdata;
  logic          mem_stall;
  lc3b_word      rdata_out;
  logic          rdata_valid;
  logic          mem_err;

  int n_checks = 0;
  int n_fails  = 0;
  logic [15:0] mem [int];

  mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem2_read(mem2_read), .mem2_write(mem2_write),
    .addr(addr), .wdata(wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .mem_stall(mem_stall),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ctl(input string tag, input logic rd, input logic wr,
                           input logic stall, input logic valid);
    check_eq({tag, ".dmem_read"},   16'(dmem_read),   16'(rd));
    check_eq({tag, ".dmem_write"},  16'(dmem_write),  16'(wr));
    check_eq({tag, ".mem_stall"},   16'(mem_stall),   16'(stall));
    check_eq({tag, ".rdata_valid"}, 16'(rdata_valid), 16'(valid));
  endtask

  // Unwritten words read back a fixed scramble of their index.
  function automatic logic [15:0] mem_rd(input int idx);
    logic [31:0] t;
    if (mem.exists(idx)) return mem[idx];
    t = idx * 40503;
    return t[15:0] ^ 16'h1234;
  endfunction

  // One memory access as seen from the memory side: request held lat cycles, then respond.
  task automatic do_access(input lc3b_word a, input logic wr, input logic [1:0] m,
                           input lc3b_word wd, input int lat, output lc3b_word rd);
    lc3b_word old;
    rd = mem_rd(int'(a[15:1]));
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check_ctl("access", !wr, wr, 1'b1, 1'b0);
      check_eq("dmem_address", dmem_address, a);
      check_eq("dmem_wmask", 16'(dmem_wmask), 16'(m));
      if (wr) check_eq("dmem_wdata", dmem_wdata, wd);
      if (c == lat - 1) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rd;
      end
      @(posedge clk); #1;
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
    end
    if (wr) begin
      old = mem_rd(int'(a[15:1]));
      mem[int'(a[15:1])] = {m[1] ? wd[15:8] : old[15:8], m[0] ? wd[7:0] : old[7:0]};
    end
  endtask

  // Issue one instruction (called just after a rising edge); returns just after S_DONE ends.
  task automatic run_instr(input lc3b_opcode op, input lc3b_word a, input lc3b_word wd,
                           input int lat_fix);
    logic     st, bt, in;
    lc3b_word ptr, dat, daddr, exp_wd, exp_rd;
    logic [1:0] m;
    st = (op == op_str) || (op == op_stb) || (op == op_sti);
    bt = (op == op_ldb) || (op == op_stb);
    in = (op == op_ldi) || (op == op_sti);
    opcode = op; addr = a; wdata = wd; mem2_read = !st; mem2_write = st;
    @(negedge clk);
    check_ctl("idle_req", 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    if (in) begin
      do_access({a[15:1], 1'b0}, 1'b0, 2'b00, 16'h0000,
                lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4)), ptr);
      daddr = {ptr[15:1], 1'b0};
    end else begin
      daddr = bt ? a : {a[15:1], 1'b0};
    end
    m      = !st ? 2'b00 : (bt ? (a[0] ? 2'b10 : 2'b01) : 2'b11);
    exp_wd = bt ? {wd[7:0], wd[7:0]} : wd;
    do_access(daddr, st, m, exp_wd, lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4)), dat);
    @(negedge clk);
    check_ctl("done", 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("done.mem_err", 16'(mem_err), 16'h0000);
    if (!st) begin
      exp_rd = (op == op_ldb) ? {8'h00, a[0] ? dat[15:8] : dat[7:0]} : dat;
      check_eq("rdata_out", rdata_out, exp_rd);
    end
    @(posedge clk); #1;
    mem2_read = 1'b0; mem2_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  lc3b_opcode ops [6];
  lc3b_opcode rop;
  lc3b_word   ra;

  initial begin
    ops = '{op_ldr, op_ldb, op_str, op_stb, op_ldi, op_sti};
    rst = 1'b1; opcode = op_br; mem2_read = 1'b0; mem2_write = 1'b0;
    addr = '0; wdata = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.dmem_address", dmem_address, 16'h0000);
    check_eq("reset.dmem_wmask", 16'(dmem_wmask), 16'h0000);
    check_eq("reset.dmem_wdata", dmem_wdata, 16'h0000);
    check_eq("reset.rdata_out", rdata_out, 16'h0000);
    check_eq("reset.mem_err", 16'(mem_err), 16'h0000);
    @(posedge clk); #1;

    // Directed cases.
    mem[16'h1000 >> 1] = 16'hBEEF;
    run_instr(op_ldr, 16'h1000, 16'h0000, 3);
    mem[16'h2000 >> 1] = 16'hAB12;
    run_instr(op_ldb, 16'h2001, 16'h0000, 0);
    run_instr(op_stb, 16'h2001, 16'h0034, 0);
    mem[16'h3000 >> 1] = 16'h4002;
    mem[16'h4002 >> 1] = 16'h5555;
    run_instr(op_ldi, 16'h3000, 16'h0000, 0);
    run_instr(op_sti, 16'h3000, 16'hC0DE, 0);
    run_instr(op_ldr, 16'h4002, 16'h0000, 0);
    idle_cycles(1);
    run_instr(op_str, 16'h1234, 16'h7E57, 1);
    run_instr(op_ldr, 16'h1234, 16'h0000, 1);

    // Reset while the pointer read of an LDI is outstanding.
    opcode = op_ldi; addr = 16'h3000; mem2_read = 1'b1; mem2_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_ctl("ind_before_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; mem2_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_ctl("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    idle_cycles(2);

`ifdef MEM_TIMEOUT_EN
    // No response at all: abort after 8 request cycles.
    opcode = op_ldr; addr = 16'h1000; mem2_read = 1'b1; mem2_write = 1'b0;
    @(negedge clk);
    check_ctl("to_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_ctl("to_wait", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    check_ctl("to_done", 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("to_done.mem_err", 16'(mem_err), 16'h0001);
    check_eq("to_done.rdata_out", rdata_out, 16'h0000);
    @(posedge clk); #1;
    mem2_read = 1'b0;
    @(negedge clk);
    check_ctl("to_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("to_after.mem_err", 16'(mem_err), 16'h0000);
    @(posedge clk); #1;
`endif

    // Random instruction stream over a small address pool so stores feed later loads.
    for (int n = 0; n < 200; n++) begin
      rop = ops[$urandom_range(0, 5)];
      ra  = {8'h20, 8'($urandom_range(0, 63))};
      run_instr(rop, ra, 16'($urandom), 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory initiator for the LC-3b pipeline.
- Consumes the control word fields produced by decode (opcode, mem2_read, mem2_write) plus the EX/MEM address and store data.
- Drives the data-memory port (address, read, write, byte mask), sequences the two-access LDI/STI indirection and LDB/STB byte lanes, and holds a pipeline stall until the final access completes.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for dmem_resp per access before abort (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active high
- opcode  in  4  lc3b_opcode of the instruction in MEM
- mem2_read  in  1  control word: instruction reads data memory
- mem2_write  in  1  control word: instruction writes data memory
- addr  in  16  effective address from EX/MEM
- wdata  in  16  store data from EX/MEM
- dmem_rdata  in  16  memory read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse from memory
- dmem_address  out  16  memory address
- dmem_read  out  1  read request, held until dmem_resp
- dmem_write  out  1  write request, held until dmem_resp
- dmem_wmask  out  2  byte enables [1]=high byte, [0]=low byte
- dmem_wdata  out  16  memory write data
- mem_stall  out  1  freezes IF/ID, ID/EX and EX/MEM loads
- rdata_out  out  16  load result to MEM/WB (zero-extended for LDB)
- rdata_valid  out  1  rdata_out valid this cycle
- mem_err  out  1  access aborted (tied 0 without the optional feature)

Behaviour:
- Definitions: req = mem2_read | mem2_write. ind = opcode is op_ldi or op_sti. byte = opcode is op_ldb or op_stb.
- States:
  - S_IDLE: if req and ind, go to S_IND; if req and not ind, go to S_DATA; otherwise stay.
  - S_IND: dmem_read=1, dmem_address={addr[15:1],0}. On dmem_resp, capture dmem_rdata into ptr_reg and go to S_DATA.
  - S_DATA: dmem_address = ind ? {ptr_reg[15:1],0} : (byte ? addr : {addr[15:1],0}). dmem_read=1 for LDR/LDB/LDI; dmem_write=1 for STR/STB/STI. On dmem_resp, capture dmem_rdata into data_reg and go to S_DONE.
  - S_DONE: rdata_valid=1, mem_stall=0. Unconditionally go to S_IDLE.
- Stall:
  - mem_stall = (S_IDLE & req) | S_IND | S_DATA.
  - A single-access instruction stalls for 1 + memory latency cycles; the pipeline advances at the end of the S_DONE cycle.
  - S_DONE never samples req, so the same instruction cannot re-trigger.
- Byte lanes:
  - Word access: wmask=2'b11, dmem_wdata=wdata.
  - STB: wmask = addr[0] ? 2'b10 : 2'b01; dmem_wdata={wdata[7:0],wdata[7:0]}.
  - LDB: rdata_out = {8'h00, addr[0] ? data_reg[15:8] : data_reg[7:0]}.
  - Reads: wmask=2'b00.
- Outputs outside S_DONE: rdata_out holds data_reg; rdata_valid=0.
- dmem_read and dmem_write are never both 1. Requests are stable from assertion until the dmem_resp cycle and drop the cycle after it.
- dmem_resp arriving in S_IDLE or S_DONE is ignored.
- Reset values: state=S_IDLE; ptr_reg=0; data_reg=0; all outputs 0 (dmem_address=0, mem_stall=0).
- Reset mid-access: the FSM returns to S_IDLE on the next edge and dmem_read/dmem_write deassert; any later stray dmem_resp is ignored.
- The opcode/addr/wdata inputs are stable while mem_stall=1 because EX/MEM is frozen; the block does not register them.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to S_IND and to S_DATA, and increments each cycle without dmem_resp.
  - When the counter reaches TIMEOUT_CYCLES-1 without dmem_resp, go to S_DONE with mem_err=1 for that cycle and rdata_out=16'h0000.
  - Requests drop on that transition.
- MEM_TIMEOUT_EN undefined:
  - No counter; the block waits indefinitely; mem_err is constant 0.

Decomposition:
- lc3b_types (shared): lc3b_word, lc3b_opcode and op_* values, and a new lc3b_mem_wmask (2-bit) typedef.
- FSM state enum stays local to the module.
- One combinational sub-module, mem_byte_align: addr[0], byte flag, wdata and raw read data in; wmask, dmem_wdata and aligned/zero-extended rdata out.

Test Plan:
- LDR, addr=x1000, dmem_resp 3 cycles after request with rdata=xBEEF -> dmem_address=x1000, dmem_read held 3 cycles, mem_stall high 4 cycles, then rdata_out=xBEEF with rdata_valid=1 for 1 cycle.
- LDB at addr=x2001, rdata=xAB12 -> rdata_out=x00AB. STB at x2001 with wdata=x0034 -> wmask=2'b10, dmem_wdata=x3434.
- LDI, addr=x3000, pointer read returns x4002, data read returns x5555 -> two reads (x3000, then x4002), rdata_out=x5555. STI -> read then write, dmem_write asserted only in the second access.
- Back-to-back STR then LDR with 1-cycle memory -> no overlapping requests; exactly one S_DONE per instruction; the second instruction starts the cycle after S_DONE.
- rst asserted during S_IND of an LDI -> next cycle dmem_read=0, mem_stall=0; a stray dmem_resp afterwards causes no state change.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no dmem_resp -> abort after 8 cycles with mem_err=1 for 1 cycle, rdata_out=0, FSM back in S_IDLE.
